// File: rtl/booth_pkg.sv
// Shared types for the radix-4 Booth sequential multiplier: FSM states, digit codes
// and the iteration-counter width helper.
package booth_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  typedef enum logic [2:0] {ZERO, POS1, POS2, NEG1, NEG2} digit_t;

  // Counter must hold WIDTH/2+1 (the digit count).
  function automatic int cnt_width(input int width);
    return $clog2(width / 2 + 2);
  endfunction

endpackage

// File: rtl/booth_r4_seq_mult_if.sv
// Start/busy/done handshake bundle for booth_r4_seq_mult.
// Optional BOOTH_ACCUM_EN adds the accumulate-preload signals acc_en/acc_in.
interface booth_r4_seq_mult_if #(parameter int WIDTH = 32);

  logic                 start;
  logic                 is_signed;
  logic [WIDTH-1:0]     multiplicand;
  logic [WIDTH-1:0]     multiplier;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;
`ifdef BOOTH_ACCUM_EN
  logic                 acc_en;
  logic [2*WIDTH-1:0]   acc_in;

  modport master (output start, is_signed, multiplicand, multiplier, acc_en, acc_in,
                  input  busy, done, product);
  modport slave  (input  start, is_signed, multiplicand, multiplier, acc_en, acc_in,
                  output busy, done, product);
`else
  modport master (output start, is_signed, multiplicand, multiplier,
                  input  busy, done, product);
  modport slave  (input  start, is_signed, multiplicand, multiplier,
                  output busy, done, product);
`endif

endinterface

// File: rtl/booth_r4_recoder.sv
// Combinational radix-4 Booth recoder: multiplier triplet -> digit, and the
// matching 0/+-A/+-2A partial product of the (already aligned) multiplicand.
module booth_r4_recoder
  import booth_pkg::*;
#(
  parameter int AW = 66
) (
  input  logic [2:0]           triplet,
  input  logic signed [AW-1:0] mcand,
  output logic signed [AW-1:0] pp
);

  digit_t digit;

  always_comb begin
    digit = ZERO;
    case (triplet)
      3'b001, 3'b010: digit = POS1;
      3'b011:         digit = POS2;
      3'b100:         digit = NEG2;
      3'b101, 3'b110: digit = NEG1;
      default:        digit = ZERO;
    endcase
  end

  always_comb begin
    pp = '0;
    case (digit)
      POS1:    pp = mcand;
      POS2:    pp = mcand <<< 1;
      NEG1:    pp = -mcand;
      NEG2:    pp = -(mcand <<< 1);
      default: pp = '0;
    endcase
  end

endmodule

// File: rtl/booth_r4_seq_mult.sv
// Iterative radix-4 Booth multiplier, one digit per cycle, signed/unsigned per operation.
// Define BOOTH_ACCUM_EN to add acc_en/acc_in accumulator preload (product = A*B + acc_in).
module booth_r4_seq_mult
  import booth_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic              clk,
  input logic              rst_n,
  booth_r4_seq_mult_if.slave bus
);

  localparam int AW = 2 * WIDTH + 2;
  localparam int BW = WIDTH + 3;
  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] NDIG = CW'(WIDTH / 2 + 1);

  generate
    if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
      $error("booth_r4_seq_mult: WIDTH must be even and >= 4");
    end
  endgenerate

  state_t                state;
  logic [CW-1:0]         cnt;
  logic                  accept;
  logic                  sa, sb;
  logic signed [AW-1:0]  ext_a;
  logic [WIDTH+1:0]      ext_b;
  logic signed [AW-1:0]  acc_init;
  logic signed [AW-1:0]  acc;
  logic signed [AW-1:0]  mcand;
  logic signed [AW-1:0]  pp;
  logic [BW-1:0]         mplr;

  assign accept = (state == IDLE) && bus.start;
  assign sa     = bus.is_signed & bus.multiplicand[WIDTH-1];
  assign sb     = bus.is_signed & bus.multiplier[WIDTH-1];
  assign ext_a  = {{(AW - WIDTH){sa}}, bus.multiplicand};
  assign ext_b  = {{2{sb}}, bus.multiplier};

`ifdef BOOTH_ACCUM_EN
  logic sc;
  assign sc       = bus.is_signed & bus.acc_in[2*WIDTH-1];
  assign acc_init = bus.acc_en ? {{2{sc}}, bus.acc_in} : '0;
`else
  assign acc_init = '0;
`endif

  // Multiplicand is pre-shifted instead of shifting the accumulator right.
  booth_r4_recoder #(.AW(AW)) u_recoder (
    .triplet (mplr[2:0]),
    .mcand   (mcand),
    .pp      (pp)
  );

  // Control and result: product is registered on leaving DONE so done and product rise together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.product <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state    <= CALC;
            cnt      <= NDIG;
            bus.busy <= 1'b1;
          end
        end
        CALC: begin
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= DONE;
        end
        DONE: begin
          state       <= IDLE;
          bus.busy    <= 1'b0;
          bus.done    <= 1'b1;
          bus.product <= acc[2*WIDTH-1:0];
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath: operands reload on every accepted start, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (accept) begin
      acc   <= acc_init;
      mcand <= ext_a;
      mplr  <= {ext_b, 1'b0};
    end else if (state == CALC) begin
      acc   <= acc + pp;
      mcand <= mcand <<< 2;
      mplr  <= mplr >> 2;
    end
  end

endmodule

// File: tb/tb_booth_r4_seq_mult.sv
// Scoreboard bench for booth_r4_seq_mult (WIDTH=32): directed corner cases plus
// randomized operations checked against a plain-arithmetic reference model.
module tb_booth_r4_seq_mult;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  booth_r4_seq_mult_if #(.WIDTH(W)) bus();

  booth_r4_seq_mult #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [2*W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic s, input logic ae,
                                           input logic [2*W-1:0] ai);
    longint   sa, sb;
    logic [2*W-1:0] p;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      p  = 64'(sa * sb);
    end else begin
      p = {32'b0, a} * {32'b0, b};
    end
    if (ae) p = p + ai;
    return p;
  endfunction

  task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse retires the oldest expected product.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: product 0x%h with no pending operation", bus.product);
      end else begin
        check("product", bus.product, exp_q.pop_front());
      end
    end
  end

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 6))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Called at a negedge; returns at the negedge where done is seen.
  // noise=1 scrambles operands every busy cycle and pulses start mid-CALC and in DONE.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input logic ae, input logic [2*W-1:0] ai, input bit noise);
    int lat;
    int guard;
    guard = 0;
    while (bus.busy === 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    bus.start        = 1'b1;
    bus.multiplicand = a;
    bus.multiplier   = b;
    bus.is_signed    = s;
`ifdef BOOTH_ACCUM_EN
    bus.acc_en = ae;
    bus.acc_in = ai;
`endif
    exp_q.push_back(model(a, b, s, ae, ai));
    @(negedge clk);
    bus.start = 1'b0;
    lat = 0;
    while (bus.done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
      if (noise && bus.done !== 1'b1) begin
        bus.multiplicand = $urandom;
        bus.multiplier   = $urandom;
        bus.is_signed    = ~bus.is_signed;
        bus.start        = (lat == 5 || lat == 17);
      end
    end
    bus.start = 1'b0;
    check("latency", 64'(lat), 64'd18);
    check("busy_at_done", 64'(bus.busy), 64'd0);
  endtask

  initial begin
    logic [W-1:0] a, b;
    logic s, ae;
    logic [2*W-1:0] ai;
    int bad;

    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.is_signed = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier = '0;
`ifdef BOOTH_ACCUM_EN
    bus.acc_en = 1'b0;
    bus.acc_in = '0;
`endif
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_done", 64'(bus.done), 64'd0);
    check("reset_product", bus.product, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic signed product, then one-cycle done and busy low afterwards.
    run_op(32'd5, 32'd6, 1'b1, 1'b0, '0, 1'b0);
    @(negedge clk);
    check("done_one_cycle", 64'(bus.done), 64'd0);
    check("busy_after_done", 64'(bus.busy), 64'd0);

    run_op(-32'sd4, -32'sd7, 1'b1, 1'b0, '0, 1'b0);
    run_op(32'd10, -32'sd4, 1'b1, 1'b0, '0, 1'b0);
    run_op(-32'sd50, 32'd5, 1'b1, 1'b0, '0, 1'b0);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, '0, 1'b0);
    run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, '0, 1'b0);
    check("smin_sq_const", model(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, '0),
          64'h4000_0000_0000_0000);
    run_op(32'd1234, 32'd0, 1'b0, 1'b0, '0, 1'b0);
    run_op(32'd99, 32'd1, 1'b0, 1'b0, '0, 1'b0);

    // Product must hold with no further done pulses while idle.
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.product !== 64'd99 || bus.done !== 1'b0) bad++;
    end
    check("idle_hold_errors", 64'(bad), 64'd0);

    // Operand churn and ignored starts while busy.
    run_op(32'd12345, -32'sd321, 1'b1, 1'b0, '0, 1'b1);
    bad = 0;
    repeat (25) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) bad++;
    end
    check("no_extra_op_errors", 64'(bad), 64'd0);

    // Asynchronous reset mid-calculation discards the operation.
    bus.start = 1'b1;
    bus.multiplicand = 32'd7;
    bus.multiplier = 32'd9;
    bus.is_signed = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", 64'(bus.busy), 64'd0);
    check("rst_mid_done", 64'(bus.done), 64'd0);
    check("rst_mid_product", bus.product, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(32'd32, 32'd23, 1'b0, 1'b0, '0, 1'b0);

`ifdef BOOTH_ACCUM_EN
    run_op(32'd3, 32'd4, 1'b1, 1'b1, 64'd100, 1'b0);
`endif

    // Randomized back-to-back operations.
    for (int i = 0; i < 40; i++) begin
      a  = pick_operand();
      b  = pick_operand();
      s  = 1'($urandom_range(0, 1));
`ifdef BOOTH_ACCUM_EN
      ae = 1'($urandom_range(0, 1));
      ai = {$urandom, $urandom};
`else
      ae = 1'b0;
      ai = '0;
`endif
      run_op(a, b, s, ae, ai, 1'b0);
    end

    repeat (30) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog expired");
  end

endmodule
